mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request-side controller for the team's swap-on-write memory: accepts single-word read/write commands over a valid/ready request channel, drives the memory's write and read ports, and returns read data over a valid/ready response channel. The memory stores words written to upper-half addresses (MSB of address = 1) with their two halves swapped. This block sits between any client and that memory and, optionally, undoes the swap on read-back.

## Interface
- WIDTH, 8: data word width; must be even, ≥2.
- PSIZE, 4: address width; DEPTH = 2**PSIZE.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  PSIZE  word address.
- req_data  in  WIDTH  write data (ignored for reads).
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_data  out  WIDTH  read data.
- rsp_addr  out  PSIZE  address of the returned word.
- mem_wr  out  1  memory write strobe.
- mem_wr_addr  out  PSIZE  memory write address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_rd_addr  out  PSIZE  memory read address.
- mem_rdata  in  WIDTH  memory registered read data (valid the cycle after the edge that samples mem_rd).

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On accept, latch wr/addr/data into command register → ISSUE.
- ISSUE: one cycle. Write: mem_wr=1, mem_wr_addr/mem_wdata from command register (data unmodified) → IDLE. Read: mem_rd=1, mem_rd_addr = command addr → WAIT.
- WAIT: one cycle; mem_rdata is valid; capture into rsp_data (post-processed, see Configuration), rsp_addr = command addr → RESP.
- RESP: rsp_valid=1; rsp_data/rsp_addr held stable until rsp_ready. On rsp_ready → IDLE.
- req_ready=0 in every state except IDLE; one command in flight, no queuing.
- mem_wr and mem_rd never asserted together and only in ISSUE; all memory-side outputs registered/decoded from state only, no combinational path from req_* or rsp_ready.
- Upper half: addr[PSIZE-1]=1. Half-swap: {d[WIDTH/2-1:0], d[WIDTH-1:WIDTH/2]}.

## Timing
- Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_addr=0, mem_wr=0, mem_rd=0, mem addresses/data=0.
- Write: accept at edge E → mem_wr high cycle E+1 → req_ready high again cycle E+2.
- Read: accept at edge E → mem_rd cycle E+1 → capture at edge E+2 → rsp_valid cycle E+3 (minimum 3-cycle latency); next accept no earlier than the edge completing the response handshake.
- Read after write to same address returns the new value (write completes before next ISSUE).
- rsp_ready held low: stays in RESP indefinitely, outputs stable.
- rsp_ready high already on entry to RESP: handshake completes that cycle.
- Reset mid-operation: in-flight command and pending response dropped; no mem strobe in the cycle after reset asserts.

## Configuration
- MEM_REQ_UNSWAP_EN defined: read data from upper-half addresses is half-swapped before capture, so reads return exactly the word written; lower-half data passes unchanged.
- Undefined: mem_rdata captured raw for all addresses (upper-half reads return swapped halves).

## Structure
- Package mem_req_pkg: state enum (IDLE, ISSUE, WAIT, RESP), half_swap function parameterized on WIDTH, upper-half test function.
- One combinational sub-module, mem_half_swap (WIDTH parameter, in/out plus enable), instantiated on the read-capture path; tied disabled when MEM_REQ_UNSWAP_EN is undefined.

## Test plan
- Reset, read addr 5 → rsp_data=0x00, rsp_addr=5, rsp_valid exactly 3 cycles after accept.
- Write 0xA5 to addr 3, read addr 3 → mem_wdata=0xA5 on mem_wr cycle; rsp_data=0xA5.
- Write 0x3C to addr 12, read addr 12 → with MEM_REQ_UNSWAP_EN rsp_data=0x3C; without rsp_data=0xC3.
- Read addr 12, rsp_ready low 5 cycles → rsp_valid high, rsp_data stable, req_ready=0 throughout; no mem_rd after the first.
- Back-to-back write 0x11@1 then read @1 with req_valid held → second accept cycle after write ISSUE; rsp_data=0x11; mem_wr and mem_rd never coincide.
- Assert rst_n=0 in WAIT → next cycle rsp_valid=0, req_ready=1, no response ever emitted for that read.

Source files
------------

// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types and helpers for the swap-on-write memory
// request controller.
//   state_e   : controller FSM states (IDLE, ISSUE, WAIT, RESP)
//   half_swap : swaps the two halves of a w-bit word, {d[w/2-1:0], d[w-1:w/2]}
//   is_upper  : 1 when the MSB of a psize-bit address is set
// Both helpers work on zero-extended MAX_W / MAX_A wide vectors so that one
// function body serves every WIDTH / PSIZE. Callers cast the arguments up and
// cast the result back down to their own width.
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned MAX_W     = 64;
  localparam int unsigned W_IDX_W   = $clog2(MAX_W);
  localparam int unsigned MAX_A     = 32;
  localparam int unsigned A_IDX_W   = $clog2(MAX_A);

  // Result bit i takes source bit (i + w/2) mod w, which rotates the word by
  // half its width: the low half moves up and the high half moves down.
  function automatic logic [MAX_W-1:0] half_swap(input logic [MAX_W-1:0] d,
                                                 input int unsigned      w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[W_IDX_W'(i)] = d[W_IDX_W'((i + w / 2) % w)];
    end
    return r;
  endfunction

  function automatic logic is_upper(input logic [MAX_A-1:0] a,
                                    input int unsigned      psize);
    return a[A_IDX_W'(psize - 1)];
  endfunction

endpackage

// File: rtl/mem_half_swap.sv
// mem_half_swap: combinational half-swap of a data word.
//   WIDTH  : word width (even, >= 2)
//   in_i   : input word
//   en_i   : 1 = output the half-swapped word, 0 = pass in_i through
//   out_o  : result
module mem_half_swap
  import mem_req_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] swapped;

  assign swapped = WIDTH'(half_swap(MAX_W'(in_i), WIDTH));
  assign out_o   = en_i ? swapped : in_i;

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request-side controller for the swap-on-write memory.
// Accepts one read/write command at a time on a valid/ready request channel,
// issues it to the memory's write or read port, and returns read data on a
// valid/ready response channel.
//
// Parameters: WIDTH (data width, even, >= 2), PSIZE (address width).
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   req_valid/req_ready/req_wr/
//   req_addr/req_data                   command channel
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_addr                            read response channel
//   mem_wr/mem_wr_addr/mem_wdata        memory write port
//   mem_rd/mem_rd_addr/mem_rdata        memory read port (rdata registered,
//                                       valid the cycle after mem_rd)
// Build option: MEM_REQ_UNSWAP_EN -- when defined, read data from upper-half
// addresses is half-swapped back before capture so reads return the word as
// written; otherwise read data is captured raw.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PSIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [PSIZE-1:0] req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [PSIZE-1:0] rsp_addr,
  output logic             mem_wr,
  output logic [PSIZE-1:0] mem_wr_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_rd,
  output logic [PSIZE-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_e           state_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [PSIZE-1:0] rsp_addr_q;
  logic             mem_wr_q;
  logic             mem_rd_q;
  logic             cmd_wr_q;
  logic [PSIZE-1:0] cmd_addr_q;
  logic [WIDTH-1:0] cmd_data_q;

  logic             unswap_en;
  logic [WIDTH-1:0] rdata_post;

`ifdef MEM_REQ_UNSWAP_EN
  assign unswap_en = is_upper(MAX_A'(cmd_addr_q), PSIZE);
`else
  assign unswap_en = 1'b0;
`endif

  mem_half_swap #(
    .WIDTH (WIDTH)
  ) u_rd_swap (
    .in_i  (mem_rdata),
    .en_i  (unswap_en),
    .out_o (rdata_post)
  );

  // Strobes are set on the accept edge and cleared when leaving ISSUE, so they
  // are high exactly while the FSM sits in ISSUE and never depend on inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cmd_wr_q    <= req_wr;
            cmd_addr_q  <= req_addr;
            cmd_data_q  <= req_data;
            mem_wr_q    <= req_wr;
            mem_rd_q    <= !req_wr;
            req_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_wr_q <= 1'b0;
          mem_rd_q <= 1'b0;
          if (cmd_wr_q) begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          rsp_data_q  <= rdata_post;
          rsp_addr_q  <= cmd_addr_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_rd_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_addr    = rsp_addr_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wr_addr = cmd_addr_q;
  assign mem_wdata   = cmd_data_q;
  assign mem_rd      = mem_rd_q;
  assign mem_rd_addr = cmd_addr_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed, table-driven bench for mem_req_ctrl with a
// behavioural swap-on-write memory (upper-half writes stored half-swapped,
// registered read data). Expected read values are hand-computed constants
// for both MEM_REQ_UNSWAP_EN builds.
module tb_mem_req_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PSIZE = 4;

`ifdef MEM_REQ_UNSWAP_EN
  localparam bit UNSW = 1'b1;
`else
  localparam bit UNSW = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [PSIZE-1:0] req_addr;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [PSIZE-1:0] rsp_addr;
  logic             mem_wr;
  logic [PSIZE-1:0] mem_wr_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_rd;
  logic [PSIZE-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;
  int rd_pulses = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(
    .WIDTH (WIDTH),
    .PSIZE (PSIZE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_addr    (rsp_addr),
    .mem_wr      (mem_wr),
    .mem_wr_addr (mem_wr_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_rd_addr (mem_rd_addr),
    .mem_rdata   (mem_rdata)
  );

  // Swap-on-write memory model.
  logic [WIDTH-1:0] mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_wr_addr[PSIZE-1]) mem[mem_wr_addr] <= {mem_wdata[3:0], mem_wdata[7:4]};
      else                      mem[mem_wr_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe exclusivity and read-pulse counting, every cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("wr_rd_exclusive", 32'(mem_wr & mem_rd), 32'd0);
      if (mem_rd) rd_pulses++;
    end
  end

  typedef struct {
    logic             wr;
    logic [PSIZE-1:0] addr;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp;
    logic             pre;   // rsp_ready already high on entry to RESP
  } vec_t;

  // Called right after the accept edge of a read.
  task automatic read_tail(input logic [PSIZE-1:0] addr, input logic [WIDTH-1:0] exp,
                           input bit pre, input int stall);
    int pulses0;
    @(negedge clk);
    check("rd_strobe", 32'(mem_rd), 32'd1);
    check("rd_addr", 32'(mem_rd_addr), 32'(addr));
    check("rd_no_wr", 32'(mem_wr), 32'd0);
    check("rd_busy_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rd_wait_no_valid", 32'(rsp_valid), 32'd0);
    check("rd_strobe_off", 32'(mem_rd), 32'd0);
    if (pre) rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(exp));
    check("rsp_addr", 32'(rsp_addr), 32'(addr));
    pulses0 = rd_pulses;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'(exp));
      check("stall_addr", 32'(rsp_addr), 32'(addr));
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    check("stall_no_rd", 32'(rd_pulses - pulses0), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_done_valid", 32'(rsp_valid), 32'd0);
    check("rsp_done_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int stall);
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_wr    = v.wr;
    req_addr  = v.addr;
    req_data  = v.data;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (v.wr) begin
      @(negedge clk);
      check("wr_strobe", 32'(mem_wr), 32'd1);
      check("wr_addr", 32'(mem_wr_addr), 32'(v.addr));
      check("wr_data", 32'(mem_wdata), 32'(v.data));
      check("wr_busy_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("wr_done_ready", 32'(req_ready), 32'd1);
      check("wr_strobe_off", 32'(mem_wr), 32'd0);
    end else begin
      read_tail(v.addr, v.exp, v.pre, stall);
    end
  endtask

  vec_t vecs[11];

  initial begin
    int  k;
    bool_loop: begin end
    vecs[0]  = '{wr: 1'b0, addr: 4'd5,  data: 8'h00, exp: 8'h00, pre: 1'b0};
    vecs[1]  = '{wr: 1'b1, addr: 4'd3,  data: 8'hA5, exp: 8'h00, pre: 1'b0};
    vecs[2]  = '{wr: 1'b0, addr: 4'd3,  data: 8'h00, exp: 8'hA5, pre: 1'b0};
    vecs[3]  = '{wr: 1'b1, addr: 4'd12, data: 8'h3C, exp: 8'h00, pre: 1'b0};
    vecs[4]  = '{wr: 1'b0, addr: 4'd12, data: 8'h00, exp: UNSW ? 8'h3C : 8'hC3, pre: 1'b0};
    vecs[5]  = '{wr: 1'b1, addr: 4'd7,  data: 8'hF0, exp: 8'h00, pre: 1'b0};
    vecs[6]  = '{wr: 1'b0, addr: 4'd7,  data: 8'h00, exp: 8'hF0, pre: 1'b1};
    vecs[7]  = '{wr: 1'b1, addr: 4'd8,  data: 8'h12, exp: 8'h00, pre: 1'b0};
    vecs[8]  = '{wr: 1'b0, addr: 4'd8,  data: 8'h00, exp: UNSW ? 8'h12 : 8'h21, pre: 1'b1};
    vecs[9]  = '{wr: 1'b1, addr: 4'd15, data: 8'h80, exp: 8'h00, pre: 1'b0};
    vecs[10] = '{wr: 1'b0, addr: 4'd15, data: 8'h00, exp: UNSW ? 8'h80 : 8'h08, pre: 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_addr", 32'(rsp_addr), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], 0);

    // Stall: read addr 12 with rsp_ready low for 5 cycles.
    run_vec(vecs[4], 5);

    // Back-to-back: write 0x11 @1, then read @1 with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd1; req_data = 8'h11;
    @(posedge clk);
    #1 req_wr = 1'b0; req_data = 8'h00;
    k = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) check("b2b_wr_strobe", 32'(mem_wr), 32'd1);
      if (req_ready) begin
        k = c;
        break;
      end
    end
    check("b2b_ready_cycle", 32'(k), 32'd2);
    @(posedge clk);
    #1 req_valid = 1'b0;
    read_tail(4'd1, 8'h11, 1'b0, 0);

    // Reset while in WAIT: the read is dropped.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstw_issue_rd", 32'(mem_rd), 32'd1);
    @(negedge clk);
    check("rstw_in_wait", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    check("rstw_mem_rd", 32'(mem_rd), 32'd0);
    check("rstw_mem_wr", 32'(mem_wr), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
      check("rstw_idle_ready", 32'(req_ready), 32'd1);
    end
    rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
